// File: rtl/uart_tx_ctrl_pkg.sv
// ============================================================================
// uart_tx_pkg : state encodings and line levels shared by the UART TX frame path
// Rev 1.0
// ============================================================================
`default_nettype none

package uart_tx_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;
  localparam logic [2:0] STOP2  = 3'd5;

  localparam logic IDLE_LVL  = 1'b1;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = IDLE,
    ST_START  = START,
    ST_DATA   = DATA,
    ST_PARITY = PARITY,
    ST_STOP   = STOP,
    ST_STOP2  = STOP2
  } tx_state_e;

endpackage

`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
// ============================================================================
// uart_tx_ctrl_if : byte source / serializer / line bundle for uart_tx_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] p_data;
  logic                  data_valid;
  logic                  par_en;
  logic                  par_typ;
  logic                  ser_data;
  logic                  ser_done;
  logic                  ser_en;
  logic                  tx_out;
  logic                  busy;

  modport master (
    output p_data, data_valid, par_en, par_typ, ser_data, ser_done,
    input  ser_en, tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, ser_data, ser_done,
    output ser_en, tx_out, busy
  );

endinterface

`default_nettype wire

// File: rtl/uart_tx_ctrl_parity_calc.sv
// ============================================================================
// uart_parity_calc : XOR-reduce of the data word, inverted for odd parity
// Rev 1.0
// ============================================================================
`default_nettype none

module uart_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  par_typ_i,
  output logic                  par_bit_o
);

  assign par_bit_o = (^data_i) ^ par_typ_i;

endmodule

`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
// ============================================================================
// uart_tx_ctrl : UART TX frame sequencer (start/data/parity/stop onto tx_out)
// Rev 1.0 -- UART_TX_TWO_STOP_EN adds a second stop bit
// ============================================================================
`default_nettype none

module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  uart_tx_ctrl_if.slave  bus
);

  tx_state_e state_q, state_d;
  logic      par_en_q;
  logic      par_bit_q;
  logic      par_bit_d;
  logic      accept;
  logic      tx_line;
  logic      busy_flag;
  logic      ser_en_flag;

  uart_parity_calc #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_parity (
    .data_i    (bus.p_data),
    .par_typ_i (bus.par_typ),
    .par_bit_o (par_bit_d)
  );

  // par_typ only matters through par_bit_q, which already folds it in
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        par_en_q  <= bus.par_en;
        par_bit_q <= par_bit_d;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    tx_line     = IDLE_LVL;
    busy_flag   = 1'b0;
    ser_en_flag = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.data_valid) begin
          accept  = 1'b1;
          state_d = ST_START;
        end
      end

      ST_START: begin
        tx_line     = START_LVL;
        busy_flag   = 1'b1;
        ser_en_flag = 1'b1;
        state_d     = ST_DATA;
      end

      ST_DATA: begin
        tx_line     = bus.ser_data;
        busy_flag   = 1'b1;
        ser_en_flag = 1'b1;
        if (bus.ser_done) begin
          state_d = par_en_q ? ST_PARITY : ST_STOP;
        end
      end

      ST_PARITY: begin
        tx_line   = par_bit_q;
        busy_flag = 1'b1;
        state_d   = ST_STOP;
      end

`ifdef UART_TX_TWO_STOP_EN
      ST_STOP: begin
        tx_line   = STOP_LVL;
        busy_flag = 1'b1;
        state_d   = ST_STOP2;
      end

      ST_STOP2: begin
        tx_line   = STOP_LVL;
        busy_flag = 1'b1;
        if (bus.data_valid) begin
          accept  = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
`else
      // Last stop cycle doubles as an accept slot for back-to-back frames
      ST_STOP: begin
        tx_line   = STOP_LVL;
        busy_flag = 1'b1;
        if (bus.data_valid) begin
          accept  = 1'b1;
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.tx_out = tx_line;
  assign bus.busy   = busy_flag;
  assign bus.ser_en = ser_en_flag;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
// ============================================================================
// tb_uart_tx_ctrl : directed bench for uart_tx_ctrl with a behavioural serializer
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_ctrl;

`ifdef UART_TX_TWO_STOP_EN
  localparam int NSTOP = 2;
`else
  localparam int NSTOP = 1;
`endif

  logic clk;
  logic rst;

  uart_tx_ctrl_if #(.DATA_WIDTH(8)) bus ();

  uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serializer model: loads when ser_en is low, holds bit 0 through START,
  // then presents one bit per DATA cycle and flags the eighth.
  logic [7:0] sh;
  int         sh_cnt;
  logic       sh_first;
  logic       suppress_done;
  logic       force_done;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sh       <= 8'h00;
      sh_cnt   <= 0;
      sh_first <= 1'b0;
    end else if (!bus.ser_en && bus.data_valid) begin
      sh       <= bus.p_data;
      sh_cnt   <= 0;
      sh_first <= 1'b1;
    end else if (bus.ser_en) begin
      if (sh_first) begin
        sh_first <= 1'b0;
      end else begin
        sh     <= sh >> 1;
        sh_cnt <= sh_cnt + 1;
      end
    end
  end

  assign bus.ser_data = sh[0];
  assign bus.ser_done = (bus.ser_en && !sh_first && (sh_cnt == 7) && !suppress_done) || force_done;

  int          checks;
  int          failures;
  logic [31:0] cap_tx;
  int          cap_n;
  int          cap_busy;
  int          cap_en;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic clear_cap();
    cap_tx   = '0;
    cap_n    = 0;
    cap_busy = 0;
    cap_en   = 0;
  endtask

  // Records line/busy/ser_en once per cycle, sampled on the falling edge
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_tx[cap_n] = bus.tx_out;
      cap_busy      = cap_busy + int'(bus.busy);
      cap_en        = cap_en + int'(bus.ser_en);
      cap_n++;
      @(negedge clk);
    end
  endtask

  task automatic start_frame(input logic [7:0] d, input logic pe, input logic pt, input logic hold);
    @(negedge clk);
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.data_valid = 1'b1;
    @(negedge clk);
    if (!hold) bus.data_valid = 1'b0;
  endtask

  function automatic logic [31:0] ones_from(input int lo, input int n);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i < n; i++) m[i] = 1'b1;
    return m;
  endfunction

  int          n;
  int          s;
  logic [31:0] v;

  initial begin
    checks         = 0;
    failures       = 0;
    suppress_done  = 1'b0;
    force_done     = 1'b0;
    bus.p_data     = 8'h00;
    bus.data_valid = 1'b0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    rst            = 1'b1;
    clear_cap();

    #1;
    chk("reset_tx_out", {31'd0, bus.tx_out}, 32'd1);
    chk("reset_busy",   {31'd0, bus.busy},   32'd0);
    chk("reset_ser_en", {31'd0, bus.ser_en}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // ser_done while idle must not start anything
    force_done = 1'b1;
    clear_cap();
    capture(2);
    force_done = 1'b0;
    chk("idle_ser_done_busy", cap_busy, 0);

    // 0xA5 even parity; inputs scrambled mid-frame must not matter
    start_frame(8'hA5, 1'b1, 1'b0, 1'b0);
    bus.p_data  = 8'h00;
    bus.par_en  = 1'b0;
    bus.par_typ = 1'b1;
    n = 10 + NSTOP + 1;
    clear_cap();
    capture(n);
    chk("a5_even_line",   cap_tx, 32'h14A | ones_from(10, n));
    chk("a5_even_busy",   cap_busy, 10 + NSTOP);
    chk("a5_even_ser_en", cap_en, 9);

    // 0x01 odd parity -> parity bit 0
    start_frame(8'h01, 1'b1, 1'b1, 1'b0);
    clear_cap();
    capture(n);
    chk("01_odd_line", cap_tx, 32'h002 | ones_from(10, n));
    chk("01_odd_busy", cap_busy, 10 + NSTOP);

    // 0x01 even parity -> parity bit 1
    start_frame(8'h01, 1'b1, 1'b0, 1'b0);
    clear_cap();
    capture(n);
    chk("01_even_line", cap_tx, 32'h202 | ones_from(10, n));
    chk("01_even_busy", cap_busy, 10 + NSTOP);

    // 0xFF no parity, data_valid pulsed in DATA is ignored
    start_frame(8'hFF, 1'b0, 1'b0, 1'b0);
    n = 9 + NSTOP + 3;
    clear_cap();
    capture(4);
    bus.data_valid = 1'b1;
    capture(1);
    bus.data_valid = 1'b0;
    capture(n - 5);
    chk("ff_nopar_line",   cap_tx, 32'h1FE | ones_from(9, n));
    chk("ff_nopar_busy",   cap_busy, 9 + NSTOP);
    chk("ff_nopar_ser_en", cap_en, 9);

    // 0x00 no parity, stray ser_done during START must not cut the frame short
    start_frame(8'h00, 1'b0, 1'b0, 1'b0);
    n = 9 + NSTOP + 1;
    clear_cap();
    force_done = 1'b1;
    capture(1);
    force_done = 1'b0;
    capture(n - 1);
    chk("00_nopar_line", cap_tx, ones_from(9, n));
    chk("00_nopar_busy", cap_busy, 9 + NSTOP);

    // Back-to-back 0x3C then 0xC3 with data_valid held
    start_frame(8'h3C, 1'b0, 1'b0, 1'b1);
    bus.p_data = 8'hC3;
    s = 9 + NSTOP;
    n = 2 * s + 1;
    clear_cap();
    capture(s);
    bus.data_valid = 1'b0;
    capture(n - s);
    v = 32'h0000_00C3;
    v = v << (s + 1);
    chk("b2b_line",   cap_tx, 32'h78 | ones_from(9, s) | v | ones_from(s + 9, n));
    chk("b2b_busy",   cap_busy, 2 * s);
    chk("b2b_ser_en", cap_en, 18);

    // Missing ser_done parks in DATA; reset mid-frame clears outputs at once
    suppress_done = 1'b1;
    start_frame(8'h55, 1'b1, 1'b0, 1'b0);
    clear_cap();
    capture(15);
    chk("stuck_busy",   {31'd0, bus.busy},   32'd1);
    chk("stuck_ser_en", {31'd0, bus.ser_en}, 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_tx_out", {31'd0, bus.tx_out}, 32'd1);
    chk("midrst_busy",   {31'd0, bus.busy},   32'd0);
    chk("midrst_ser_en", {31'd0, bus.ser_en}, 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    suppress_done = 1'b0;
    clear_cap();
    capture(3);
    chk("post_rst_busy", cap_busy, 0);
    chk("post_rst_line", cap_tx, 32'h7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
- Frame controller for the UART transmit path; sits directly upstream of the TX serializer.
- Accepts a parallel byte, drives the serializer enable, and sequences start, data, optional parity and stop bits onto the serial line.
- Computes parity from the accepted byte and muxes start, data, parity and stop onto tx_out.
- Reports busy to the upstream data source (register file / FIFO).

Parameters:
DATA_WIDTH, 8, width of p_data and of the data field per frame

Ports:
clk  input  1  system clock; one UART bit per clk cycle (the prescaled TX clock)
rst  input  1  asynchronous, active-high reset
p_data  input  DATA_WIDTH  byte to transmit; sampled only on acceptance
data_valid  input  1  request to send p_data
par_en  input  1  1 = insert parity bit; sampled on acceptance
par_typ  input  1  0 = even parity, 1 = odd parity; sampled on acceptance
ser_data  input  1  current data bit from the serializer, LSB first
ser_done  input  1  serializer flag, high in the cycle its last data bit is on ser_data
ser_en  output  1  serializer shift enable
tx_out  output  1  serial line, idle-high
busy  output  1  frame in progress; data_valid is ignored while high

Behaviour:
- Interface: one clock, clk; reset is rst, asynchronous, active-high. Reset forces state IDLE, tx_out=1, busy=0, ser_en=0, latched parity=0 immediately, without waiting for a clock edge.
- Moore outputs decoded from the state register:
  - IDLE: tx_out=1, busy=0, ser_en=0
  - START: tx_out=0, busy=1, ser_en=1
  - DATA: tx_out=ser_data, busy=1, ser_en=1
  - PARITY: tx_out=par_bit, busy=1, ser_en=0
  - STOP: tx_out=1, busy=1, ser_en=0
- Transitions:
  - IDLE -> START when data_valid=1.
  - START -> DATA unconditionally after 1 cycle.
  - DATA stays until ser_done=1 is sampled, then goes to PARITY if par_en_q=1, else STOP.
  - PARITY -> STOP after 1 cycle.
  - STOP -> START if data_valid=1 (back-to-back frames; re-accept occurs in STOP), else IDLE.
- Acceptance (IDLE or STOP with data_valid=1):
  - Register par_en_q and par_typ_q.
  - Register par_bit = (^p_data) XOR par_typ.
  - The serializer loads p_data itself in the same cycle, because ser_en=0 there.
- data_valid in START/DATA/PARITY has no effect; no queuing.
- Frame length with 8 data bits: 10 cycles without parity, 11 with parity. busy is high for exactly that many cycles per frame.
- Mid-frame change of par_en/par_typ/p_data has no effect on the current frame.
- ser_done asserted outside DATA is ignored.
- If ser_done never arrives, the block stays in DATA; there is no timeout.
- Illegal state encodings recover to IDLE on the next clock.

Optional Feature:
- UART_TX_TWO_STOP_EN defined: adds state STOP2 (tx_out=1, busy=1) after STOP. Back-to-back re-accept moves from STOP to STOP2. Frame becomes 11 or 12 cycles.
- Undefined: a single stop bit, with transitions exactly as above.

Decomposition:
- Package uart_tx_pkg:
  - state encoding localparams: IDLE, START, DATA, PARITY, STOP, STOP2
  - line-level constants: IDLE_LVL=1, START_LVL=0, STOP_LVL=1
- Sub-module uart_parity_calc: combinational XOR-reduce of p_data plus par_typ. The controller instantiates it and registers its output on acceptance.

Test Plan:
- Reset mid-frame: assert rst during DATA -> tx_out=1, busy=0, ser_en=0 in the same cycle; after release, idle until data_valid.
- 0xA5, par_en=1, par_typ=0 (even) -> tx_out sequence 0,1,0,1,0,0,1,0,1,0,1. busy high 11 cycles; ser_en high 9 cycles (START plus 8 DATA).
- 0x01, par_en=1, par_typ=1 (odd) -> parity bit 0. With par_typ=0 the parity bit is 1.
- 0xFF, par_en=0 -> frame 0, eight 1s, 1 (10 cycles). data_valid pulsed mid-frame is ignored; no second frame follows.
- Back-to-back: hold data_valid, send 0x3C then 0xC3, no parity -> second START immediately follows STOP with no idle cycle; 20 busy cycles total.
- UART_TX_TWO_STOP_EN defined, 0x00, no parity -> 0, eight 0s, 1, 1; busy 11 cycles.
